// File: rtl/sample_streamer.sv
// Sample FIFO feeding a downstream averager; each sample is held valid for HOLD cycles.
// Optional sticky underrun flag enabled by defining SAMPLE_STREAMER_UNDERRUN_EN.
module sample_streamer #(
    parameter int WL    = 4,
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_en,
    input  logic [WL-1:0]          wr_data,
    input  logic                   start,
    input  logic                   stop,
    output logic                   valid,
    output logic [WL-1:0]          dout,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   underrun
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int HCW = $clog2(HOLD + 1);
    localparam logic [HCW-1:0] HOLD_L  = HCW'(HOLD);
    localparam logic [CW-1:0]  DEPTH_L = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD
    } state_t;

    state_t          state, state_n;
    logic [WL-1:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [HCW-1:0]  hold_cnt, hold_n;
    logic            stop_lat, stop_n;
    logic            valid_n;
    logic [WL-1:0]   dout_n;
    logic [CW-1:0]   count_n;
    logic            full_n;
    logic            wr_acc;
    logic            pop;
    logic            have;
    logic            last;
    logic [WL-1:0]   head;
`ifdef SAMPLE_STREAMER_UNDERRUN_EN
    logic            und_set, und_clr;
`endif

    // Pop decisions use the pre-edge count, so a same-cycle write is never popped.
    assign wr_acc = wr_en && !full;
    assign have   = (count != '0);
    assign last   = (hold_cnt == HOLD_L);
    assign head   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        valid_n = valid;
        dout_n  = dout;
        hold_n  = hold_cnt;
        stop_n  = stop_lat;
`ifdef SAMPLE_STREAMER_UNDERRUN_EN
        und_set = 1'b0;
        und_clr = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                valid_n = 1'b0;
                stop_n  = 1'b0;
                if (start && have) begin
                    pop     = 1'b1;
                    dout_n  = head;
                    valid_n = 1'b1;
                    hold_n  = HCW'(1);
                    state_n = ST_SEND;
`ifdef SAMPLE_STREAMER_UNDERRUN_EN
                    und_clr = 1'b1;
`endif
                end
            end
            ST_SEND, ST_HOLD: begin
                if (last) begin
                    // A stop arriving on the final hold cycle still ends this sample.
                    stop_n = 1'b0;
                    if (stop_lat || stop) begin
                        valid_n = 1'b0;
                        state_n = ST_IDLE;
                    end else if (have) begin
                        pop     = 1'b1;
                        dout_n  = head;
                        hold_n  = HCW'(1);
                        state_n = ST_SEND;
                    end else begin
                        valid_n = 1'b0;
                        state_n = ST_IDLE;
`ifdef SAMPLE_STREAMER_UNDERRUN_EN
                        und_set = 1'b1;
`endif
                    end
                end else begin
                    hold_n  = hold_cnt + HCW'(1);
                    stop_n  = stop_lat || stop;
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
        count_n = count + CW'(wr_acc) - CW'(pop);
        full_n  = (count_n == DEPTH_L);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            hold_cnt <= '0;
            stop_lat <= 1'b0;
            valid    <= 1'b0;
            dout     <= '0;
            busy     <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(wr_acc);
            count    <= count_n;
            full     <= full_n;
            hold_cnt <= hold_n;
            stop_lat <= stop_n;
            valid    <= valid_n;
            dout     <= dout_n;
            busy     <= (state_n != ST_IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) mem[wr_ptr] <= wr_data;
    end

`ifdef SAMPLE_STREAMER_UNDERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST)          underrun <= 1'b0;
        else if (und_clr) underrun <= 1'b0;
        else if (und_set) underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: queue-based reference model, directed cases then random traffic.
module tb_sample_streamer;

    localparam int WL    = 4;
    localparam int DEPTH = 8;
    localparam int HOLD  = 2;
`ifdef SAMPLE_STREAMER_UNDERRUN_EN
    localparam bit UND_EN = 1'b1;
`else
    localparam bit UND_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_en = 1'b0;
    logic [WL-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          valid;
    logic [WL-1:0] dout;
    logic          full;
    logic [$clog2(DEPTH):0] count;
    logic          busy;
    logic          underrun;

    always #5 CLK = ~CLK;

    sample_streamer #(.WL(WL), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .stop(stop), .valid(valid), .dout(dout),
        .full(full), .count(count), .busy(busy), .underrun(underrun)
    );

    typedef struct {
        bit v;
        int d;
        int c;
        bit f;
        bit b;
        bit u;
    } exp_t;

    exp_t eq[$];
    int   sq[$];
    bit   mon_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: FIFO as a queue, the stream as "current sample, cycles shown so far".
    int mq[$];
    bit m_str = 1'b0;
    int m_cur = 0;
    int m_shown = 0;
    bit m_stop = 1'b0;
    bit m_und = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(bit r, bit we, int wd, bit st, bit sp);
        bit was_full;
        int avail;
        was_full = (mq.size() == DEPTH);
        avail    = mq.size();
        if (r) begin
            mq.delete();
            m_str = 0; m_cur = 0; m_shown = 0; m_stop = 0; m_und = 0;
        end else begin
            if (!m_str) begin
                if (st && avail > 0) begin
                    m_cur = mq.pop_front();
                    m_str = 1; m_shown = 1; m_stop = 0; m_und = 0;
                end
            end else if (m_shown < HOLD) begin
                m_shown++;
                m_stop = m_stop | sp;
            end else begin
                if (m_stop || sp) m_str = 0;
                else if (avail > 0) begin
                    m_cur = mq.pop_front();
                    m_shown = 1;
                end else begin
                    m_str = 0;
                    if (UND_EN) m_und = 1;
                end
                m_stop = 0;
            end
            if (we && !was_full) mq.push_back(wd);
        end
    endfunction

    task automatic cyc(bit r, bit we, int wd, bit st, bit sp);
        exp_t e;
        @(negedge CLK);
        RST = r; wr_en = we; wr_data = WL'(wd); start = st; stop = sp;
        model_step(r, we, wd, st, sp);
        e.v = m_str; e.d = m_cur; e.c = mq.size(); e.f = (mq.size() == DEPTH);
        e.b = m_str; e.u = m_und;
        eq.push_back(e);
        if (m_str) sq.push_back(m_cur);
        mon_en = 1'b1;
    endtask

    task automatic wr(int v);
        cyc(0, 1, v, 0, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    exp_t me;
    always @(posedge CLK) begin
        if (mon_en) begin
            #1;
            if (eq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL exp_queue: no expected record at %0t", $time);
            end else begin
                me = eq.pop_front();
                check("valid", 32'(valid), 32'(me.v));
                check("count", 32'(count), 32'(me.c));
                check("full", 32'(full), 32'(me.f));
                check("busy", 32'(busy), 32'(me.b));
                check("underrun", 32'(underrun), 32'(me.u));
                if (valid === 1'b1) begin
                    if (sq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL sample: unexpected valid with dout %0d at %0t", dout, $time);
                    end else begin
                        check("sample_dout", 32'(dout), 32'(sq.pop_front()));
                    end
                end else begin
                    if (me.v && sq.size() > 0) void'(sq.pop_front());
                    check("dout_idle", 32'(dout), 32'(me.d));
                end
            end
        end
    end

    initial begin
        // reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(1);

        // three samples then underrun
        wr(3); wr(5); wr(7);
        cyc(0, 0, 0, 1, 0);
        idle(9);

        // overfill: ninth write dropped
        for (int v = 1; v <= 9; v++) wr(v);
        idle(2);
        cyc(0, 0, 0, 1, 0);
        idle(20);

        // stop during the second sample
        wr(4); wr(6); wr(8);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1);
        idle(4);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);

        // reset mid-stream, then start on empty FIFO
        wr(2); wr(11);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 1, 5, 1, 1);
        idle(1);
        cyc(0, 0, 0, 1, 0);
        idle(3);

        // write into empty FIFO during first valid cycle
        wr(9);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 10, 0, 0);
        idle(6);
        cyc(0, 0, 0, 1, 1);
        idle(2);

        // write while full with simultaneous pop
        for (int v = 0; v < DEPTH; v++) wr(v + 3);
        cyc(0, 1, 15, 1, 0);
        idle(1);
        cyc(0, 1, 14, 0, 0);
        idle(3 * DEPTH);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0));
        end
        idle(2);

        @(posedge CLK);
        #3;
        check("exp_queue_drained", 32'(eq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
